// File: rtl/lbp_host_mem_pkg.sv
// Shared definitions for the LBP host-side memory responder.
package lbp_host_mem_pkg;

    localparam int AW_HALF_DEF = 7;
    localparam int DW_DEF      = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SERVE = 3'd2,
        ST_DUMP  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Packs a pixel coordinate into the {row, col} address format.
    function automatic logic [31:0] pack_addr(input int unsigned row,
                                              input int unsigned col,
                                              input int unsigned aw_half);
        return 32'((row << aw_half) | col);
    endfunction

endpackage

// File: rtl/lbp_host_mem_if.sv
// Handshake/bus bundle between the LBP engine side and the host memory.
interface lbp_host_mem_if
    import lbp_host_mem_pkg::*;
#(
    parameter int AW_HALF = AW_HALF_DEF,
    parameter int DW      = DW_DEF
);
    localparam int AW = 2 * AW_HALF;

    logic          start;
    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          load_ready;
    logic          gray_ready;
    logic          gray_req;
    logic [AW-1:0] gray_addr;
    logic [DW-1:0] gray_data;
    logic          lbp_valid;
    logic [AW-1:0] lbp_addr;
    logic [DW-1:0] lbp_data;
    logic          finish;
    logic          dump_valid;
    logic          dump_ready;
    logic [DW-1:0] dump_data;
    logic [AW-1:0] dump_addr;
    logic          dump_last;
    logic          done;
    logic [AW:0]   wr_count;
    logic          proto_err;

    modport master (
        output start, load_valid, load_data, gray_req, gray_addr,
               lbp_valid, lbp_addr, lbp_data, finish, dump_ready,
        input  load_ready, gray_ready, gray_data, dump_valid, dump_data,
               dump_addr, dump_last, done, wr_count, proto_err
    );

    modport slave (
        input  start, load_valid, load_data, gray_req, gray_addr,
               lbp_valid, lbp_addr, lbp_data, finish, dump_ready,
        output load_ready, gray_ready, gray_data, dump_valid, dump_data,
               dump_addr, dump_last, done, wr_count, proto_err
    );

endinterface

// File: rtl/lbp_host_dpram.sv
// Single-write memory with one asynchronous and one registered read port.
module lbp_host_dpram #(
    parameter int AW = 14,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] ard_addr,
    output logic [DW-1:0] ard_data,
    input  logic          srd_en,
    input  logic [AW-1:0] srd_addr,
    output logic [DW-1:0] srd_data
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we)
            mem[wr_addr] <= wr_data;
    end

    assign ard_data = mem[ard_addr];

    // Registered read, write-first so a same-edge write to the read address is seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            srd_data <= '0;
        else if (srd_en)
            srd_data <= (we && (wr_addr == srd_addr)) ? wr_data : mem[srd_addr];
    end

endmodule

// File: rtl/lbp_host_mem.sv
// Host-side responder: loads the image, serves engine reads, captures results, dumps them.
module lbp_host_mem
    import lbp_host_mem_pkg::*;
#(
    parameter int AW_HALF = AW_HALF_DEF,
    parameter int DW      = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    lbp_host_mem_if.slave bus
);

    localparam int AW = 2 * AW_HALF;
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_MAX = '1;
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t        state;
    logic [AW-1:0] ptr;
    logic [DW-1:0] img_rdata;
    logic          img_we;
    logic          res_we;
    logic [AW-1:0] res_waddr;
    logic [DW-1:0] res_wdata;
    logic          res_rd_en;
    logic [AW-1:0] res_rd_addr;
    logic [DW-1:0] img_sync_unused;
    logic [DW-1:0] res_async_unused;

    lbp_host_dpram #(.AW(AW), .DW(DW)) u_img_mem (
        .clk      (clk),
        .reset    (reset),
        .we       (img_we),
        .wr_addr  (ptr),
        .wr_data  (bus.load_data),
        .ard_addr (bus.gray_addr),
        .ard_data (img_rdata),
        .srd_en   (1'b0),
        .srd_addr ('0),
        .srd_data (img_sync_unused)
    );

    lbp_host_dpram #(.AW(AW), .DW(DW)) u_res_mem (
        .clk      (clk),
        .reset    (reset),
        .we       (res_we),
        .wr_addr  (res_waddr),
        .wr_data  (res_wdata),
        .ard_addr ('0),
        .ard_data (res_async_unused),
        .srd_en   (res_rd_en),
        .srd_addr (res_rd_addr),
        .srd_data (bus.dump_data)
    );

    // Zero-latency pixel read, only while serving the engine.
    assign bus.gray_data = (state == ST_SERVE && bus.gray_req) ? img_rdata : '0;
    assign bus.dump_addr = ptr;

    // Memory write steering and dump prefetch address selection.
    always_comb begin
        img_we      = (state == ST_LOAD) && bus.load_valid;
        res_we      = 1'b0;
        res_waddr   = ptr;
        res_wdata   = '0;
        res_rd_en   = 1'b0;
        res_rd_addr = ptr + 1'b1;
        case (state)
            ST_LOAD: res_we = bus.load_valid;
            ST_SERVE: begin
                res_we    = bus.lbp_valid;
                res_waddr = bus.lbp_addr;
                res_wdata = bus.lbp_data;
                if (bus.finish) begin
                    res_rd_en   = 1'b1;
                    res_rd_addr = '0;
                end
            end
            ST_DUMP: res_rd_en = bus.dump_ready && (ptr != PTR_MAX);
            default: ;
        endcase
    end

    // Frame control FSM with registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            ptr            <= '0;
            bus.load_ready <= 1'b0;
            bus.gray_ready <= 1'b0;
            bus.dump_valid <= 1'b0;
            bus.dump_last  <= 1'b0;
            bus.done       <= 1'b0;
            bus.wr_count   <= '0;
            bus.proto_err  <= 1'b0;
        end else begin
            if (state != ST_SERVE && (bus.gray_req || bus.lbp_valid))
                bus.proto_err <= 1'b1;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state          <= ST_LOAD;
                        ptr            <= '0;
                        bus.wr_count   <= '0;
                        bus.proto_err  <= 1'b0;
                        bus.done       <= 1'b0;
                        bus.load_ready <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (bus.load_valid) begin
                        ptr <= ptr + 1'b1;
                        if (ptr == PTR_MAX) begin
                            state          <= ST_SERVE;
                            bus.load_ready <= 1'b0;
                            bus.gray_ready <= 1'b1;
                        end
                    end
                end
                ST_SERVE: begin
                    if (bus.lbp_valid && bus.wr_count != CNT_MAX)
                        bus.wr_count <= bus.wr_count + 1'b1;
                    if (bus.finish) begin
                        if (bus.wr_count == '0 && !bus.lbp_valid)
                            bus.proto_err <= 1'b1;
                        state          <= ST_DUMP;
                        ptr            <= '0;
                        bus.gray_ready <= 1'b0;
                        bus.dump_valid <= 1'b1;
                        bus.dump_last  <= 1'b0;
                    end
                end
                ST_DUMP: begin
                    if (bus.dump_ready) begin
                        if (ptr == PTR_MAX) begin
                            state          <= ST_DONE;
                            bus.done       <= 1'b1;
                            bus.dump_valid <= 1'b0;
                            bus.dump_last  <= 1'b0;
                        end else begin
                            ptr           <= ptr + 1'b1;
                            bus.dump_last <= (ptr == PTR_MAX - 1'b1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lbp_host_mem.sv
// Self-checking bench for lbp_host_mem on an 8x8 image.
module tb_lbp_host_mem;
    import lbp_host_mem_pkg::*;

    localparam int AWH = 3;
    localparam int DWT = 8;
    localparam int AW  = 2 * AWH;
    localparam int N   = 1 << AW;
    localparam int CNT_SAT = (1 << (AW + 1)) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lbp_host_mem_if #(.AW_HALF(AWH), .DW(DWT)) bus ();

    lbp_host_mem #(.AW_HALF(AWH), .DW(DWT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model: plain arrays of image and result contents plus frame status.
    logic [7:0] m_img [N];
    logic [7:0] m_res [N];
    int         m_wr;
    logic       m_err;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       req;
        int         row;
        int         col;
        logic [7:0] exp;
    } rd_vec_t;
    rd_vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.start      = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.gray_req   = 1'b0;
        bus.gray_addr  = '0;
        bus.lbp_valid  = 1'b0;
        bus.lbp_addr   = '0;
        bus.lbp_data   = '0;
        bus.finish     = 1'b0;
        bus.dump_ready = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_load_ready"}, bus.load_ready, 0);
        chk({tag, "_gray_ready"}, bus.gray_ready, 0);
        chk({tag, "_gray_data"},  bus.gray_data, 0);
        chk({tag, "_dump_valid"}, bus.dump_valid, 0);
        chk({tag, "_dump_data"},  bus.dump_data, 0);
        chk({tag, "_dump_addr"},  bus.dump_addr, 0);
        chk({tag, "_dump_last"},  bus.dump_last, 0);
        chk({tag, "_done"},       bus.done, 0);
        chk({tag, "_wr_count"},   bus.wr_count, 0);
        chk({tag, "_proto_err"},  bus.proto_err, 0);
    endtask

    task automatic start_frame();
        @(negedge clk);
        idle_inputs();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        m_wr  = 0;
        m_err = 1'b0;
        chk("start_load_ready", bus.load_ready, 1);
        chk("start_proto_err", bus.proto_err, 0);
        chk("start_done", bus.done, 0);
        chk("start_wr_count", bus.wr_count, 0);
    endtask

    task automatic load_image(input bit rnd);
        int k = 0;
        int g = 0;
        logic [7:0] v;
        while (k < N && g < 1000) begin
            @(negedge clk);
            g++;
            chk("load_ready_during_load", bus.load_ready, 1);
            if ((rnd && $urandom_range(0, 3) == 0) || (!rnd && (g % 4 == 3))) begin
                bus.load_valid = 1'b0;
            end else begin
                v = rnd ? 8'($urandom) : 8'(k);
                bus.load_valid = 1'b1;
                bus.load_data  = v;
                m_img[k] = v;
                m_res[k] = 8'h00;
                k++;
            end
        end
        if (k < N) chk("load_timeout", k, N);
        @(negedge clk);
        bus.load_valid = 1'b0;
        chk("load_ready_after", bus.load_ready, 0);
        chk("gray_ready_after", bus.gray_ready, 1);
    endtask

    task automatic serve_cycle(input logic req, input int gaddr, input logic lv,
                               input int laddr, input logic [7:0] ldata,
                               input logic fin, input logic [7:0] exp_gray);
        @(negedge clk);
        chk("serve_gray_ready", bus.gray_ready, 1);
        chk("serve_wr_count", bus.wr_count, m_wr);
        chk("serve_proto_err", bus.proto_err, m_err);
        bus.gray_req  = req;
        bus.gray_addr = AW'(gaddr);
        bus.lbp_valid = lv;
        bus.lbp_addr  = AW'(laddr);
        bus.lbp_data  = ldata;
        bus.finish    = fin;
        #1;
        chk("gray_data", bus.gray_data, exp_gray);
        if (fin && m_wr == 0 && !lv) m_err = 1'b1;
        if (lv) begin
            m_res[laddr] = ldata;
            if (m_wr < CNT_SAT) m_wr++;
        end
    endtask

    // Drains the dump; ready_mode 0 = 1,0,0,1 repeating, 1 = random. reset_at >= 0 aborts with reset.
    task automatic dump_frame(input int ready_mode, input int reset_at);
        int idx = 0;
        int cyc = 0;
        logic rdy;
        while (idx < N && cyc < 2000) begin
            @(negedge clk);
            bus.gray_req  = 1'b0;
            bus.lbp_valid = 1'b0;
            bus.finish    = 1'b0;
            if (cyc == 0) begin
                chk("dump_proto_err", bus.proto_err, m_err);
                chk("dump_wr_count", bus.wr_count, m_wr);
            end
            cyc++;
            chk("dump_valid", bus.dump_valid, 1);
            chk("dump_addr", bus.dump_addr, idx);
            chk("dump_data", bus.dump_data, m_res[idx]);
            chk("dump_last", bus.dump_last, (idx == N - 1));
            if (idx == reset_at) begin
                bus.dump_ready = 1'b0;
                reset = 1'b1;
                #1;
                check_reset_vals("mid_dump_reset");
                @(negedge clk);
                reset = 1'b0;
                m_wr  = 0;
                m_err = 1'b0;
                return;
            end
            if (ready_mode == 0) rdy = (cyc % 4 == 1) || (cyc % 4 == 0);
            else                 rdy = ($urandom_range(0, 2) != 0);
            bus.dump_ready = rdy;
            if (rdy) idx++;
        end
        if (idx < N) chk("dump_timeout", idx, N);
        @(negedge clk);
        bus.dump_ready = 1'b0;
        chk("done_after_dump", bus.done, 1);
        chk("dump_valid_after", bus.dump_valid, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 2, 5, 8'd21};
        tbl[1] = '{1'b1, 0, 0, 8'd0};
        tbl[2] = '{1'b1, 7, 7, 8'd63};
        tbl[3] = '{1'b1, 3, 1, 8'd25};
        tbl[4] = '{1'b0, 6, 6, 8'd0};
        tbl[5] = '{1'b1, 5, 2, 8'd42};

        idle_inputs();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;

        // Stray result write while idle flags an error and is ignored.
        @(negedge clk);
        bus.lbp_valid = 1'b1;
        bus.lbp_addr  = AW'(5);
        bus.lbp_data  = 8'hFF;
        @(negedge clk);
        bus.lbp_valid = 1'b0;
        chk("idle_write_proto_err", bus.proto_err, 1);

        // Frame 1: ramp image, table reads, directed writes, finish with write.
        start_frame();
        load_image(1'b0);
        for (int i = 0; i < 6; i++)
            serve_cycle(tbl[i].req, int'(pack_addr(tbl[i].row, tbl[i].col, AWH)),
                        1'b0, 0, 8'h00, 1'b0, tbl[i].exp);
        serve_cycle(1'b0, 0, 1'b1, 9, 8'hA5, 1'b0, 8'h00);
        serve_cycle(1'b0, 0, 1'b1, 54, 8'h3C, 1'b0, 8'h00);
        serve_cycle(1'b0, 0, 1'b1, 63, 8'h77, 1'b1, 8'h00);
        dump_frame(0, -1);

        // Reads while done are ignored but flagged.
        @(negedge clk);
        bus.gray_req  = 1'b1;
        bus.gray_addr = AW'(3);
        #1;
        chk("done_gray_data", bus.gray_data, 0);
        @(negedge clk);
        bus.gray_req = 1'b0;
        chk("done_gray_proto_err", bus.proto_err, 1);
        chk("done_held", bus.done, 1);

        // Frame 2: random image, start ignored in SERVE, random reads/writes.
        start_frame();
        load_image(1'b1);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_ignored_serve", bus.gray_ready, 1);
        chk("start_ignored_load_ready", bus.load_ready, 0);
        for (int i = 0; i < 60; i++) begin
            logic req;
            logic lv;
            int   ga;
            req = 1'($urandom_range(0, 1));
            ga  = $urandom_range(0, N - 1);
            lv  = (i == 0) || ($urandom_range(0, 2) == 0);
            serve_cycle(req, ga, lv, $urandom_range(0, N - 1), 8'($urandom), 1'b0,
                        req ? m_img[ga] : 8'h00);
        end
        serve_cycle(1'b0, 0, 1'b0, 0, 8'h00, 1'b1, 8'h00);
        dump_frame(1, -1);

        // Frame 3: finish with no writes flags an error; reset lands mid-dump.
        start_frame();
        load_image(1'b1);
        serve_cycle(1'b1, 17, 1'b0, 0, 8'h00, 1'b0, m_img[17]);
        serve_cycle(1'b0, 0, 1'b0, 0, 8'h00, 1'b1, 8'h00);
        dump_frame(1, 20);

        // Frame 4: normal operation after the reset.
        start_frame();
        load_image(1'b0);
        serve_cycle(1'b1, int'(pack_addr(2, 5, AWH)), 1'b1, 0, 8'h5A, 1'b0, 8'd21);
        serve_cycle(1'b0, 0, 1'b1, 40, 8'hC3, 1'b1, 8'h00);
        dump_frame(0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
